// File: rtl/mips_pkg.sv
// Shared MIPS core definitions used by the multiply/divide unit:
// operation and state encodings plus the iteration count.
package mips_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_NOP6  = 3'd6,
        OP_NOP7  = 3'd7
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_t;

    localparam int MDU_ITERS = 32;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the register-file read stage and the
// multiply/divide unit that owns HI/LO.
interface muldiv_unit_if #(parameter int XLEN = 32);
    import mips_pkg::*;

    logic            start;
    mdu_op_t         op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (output start, op, a, b, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit_abs_neg.sv
// Conditional two's-complement negate; with i_negate tied to the sign bit
// it doubles as an absolute-value stage.
module mdu_abs_neg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_negate,
    output logic [WIDTH-1:0] o_value
);
    assign o_value = i_negate ? (~i_value + 1'b1) : i_value;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-step shift-add multiplier / restoring divider owning HI/LO.
// Operands are conditioned to magnitudes up front and sign-fixed in FIX.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic        clk,
    input  logic        rst,
    muldiv_unit_if.slave bus
);
    mdu_state_t        r_state;
    logic [4:0]        r_count;
    logic              r_isDiv;
    logic              r_negRes;
    logic              r_negRem;
    logic              r_divZero;
    logic              r_busy;
    logic              r_done;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_aRaw;
    logic [XLEN-1:0]   r_mcand;
    logic [2*XLEN-1:0] r_product;

    logic              w_signedOp;
    logic              w_isDivOp;
    logic              w_negA;
    logic              w_negB;
    logic [XLEN-1:0]   w_absA;
    logic [XLEN-1:0]   w_absB;
    logic [XLEN:0]     w_addHi;
    logic [XLEN:0]     w_remShift;
    logic              w_remGe;
    logic [XLEN-1:0]   w_remDiff;
    logic [2*XLEN-1:0] w_fixProd;
    logic [XLEN-1:0]   w_fixQuo;
    logic [XLEN-1:0]   w_fixRem;

    assign w_signedOp = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign w_isDivOp  = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    assign w_negA     = w_signedOp & bus.a[XLEN-1];
    assign w_negB     = w_signedOp & bus.b[XLEN-1];

    mdu_abs_neg #(.WIDTH(XLEN)) u_absA (.i_value(bus.a), .i_negate(w_negA), .o_value(w_absA));
    mdu_abs_neg #(.WIDTH(XLEN)) u_absB (.i_value(bus.b), .i_negate(w_negB), .o_value(w_absB));

    // Multiply step adds into the upper half with carry; divide step shifts
    // the next dividend bit into the partial remainder and trial-subtracts.
    assign w_addHi    = {1'b0, r_product[2*XLEN-1:XLEN]} + (r_product[0] ? {1'b0, r_mcand} : {(XLEN+1){1'b0}});
    assign w_remShift = {r_product[2*XLEN-1:XLEN], r_product[XLEN-1]};
    assign w_remGe    = w_remShift >= {1'b0, r_mcand};
    assign w_remDiff  = w_remShift[XLEN-1:0] - r_mcand;

    mdu_abs_neg #(.WIDTH(2*XLEN)) u_fixProd (.i_value(r_product), .i_negate(r_negRes), .o_value(w_fixProd));
    mdu_abs_neg #(.WIDTH(XLEN)) u_fixQuo (.i_value(r_product[XLEN-1:0]), .i_negate(r_negRes), .o_value(w_fixQuo));
    mdu_abs_neg #(.WIDTH(XLEN)) u_fixRem (.i_value(r_product[2*XLEN-1:XLEN]), .i_negate(r_negRem), .o_value(w_fixRem));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_count   <= 5'd0;
            r_isDiv   <= 1'b0;
            r_negRes  <= 1'b0;
            r_negRem  <= 1'b0;
            r_divZero <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_aRaw    <= '0;
            r_mcand   <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        case (bus.op)
                            OP_MTHI: r_hi <= bus.a;
                            OP_MTLO: r_lo <= bus.a;
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                r_isDiv   <= w_isDivOp;
                                r_negRes  <= w_negA ^ w_negB;
                                r_negRem  <= w_negA;
                                r_divZero <= w_isDivOp && (bus.b == '0);
                                r_aRaw    <= bus.a;
                                r_mcand   <= w_isDivOp ? w_absB : w_absA;
                                r_product <= {{XLEN{1'b0}}, (w_isDivOp ? w_absA : w_absB)};
                                r_count   <= 5'd0;
                                r_busy    <= 1'b1;
                                r_state   <= ST_CALC;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_CALC: begin
                    if (r_isDiv)
                        r_product <= {(w_remGe ? w_remDiff : w_remShift[XLEN-1:0]),
                                      r_product[XLEN-2:0], w_remGe};
                    else
                        r_product <= {w_addHi, r_product[XLEN-1:1]};
                    r_count <= r_count + 5'd1;
                    if (r_count == 5'(MDU_ITERS - 1))
                        r_state <= ST_FIX;
                end
                ST_FIX: begin
                    if (!r_isDiv) begin
                        {r_hi, r_lo} <= w_fixProd;
                    end else if (r_divZero) begin
                        r_hi <= r_aRaw;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_fixRem;
                        r_lo <= w_fixQuo;
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with hand-computed HI/LO
// results, latency, busy/done shape, ignored starts and mid-op reset.
module tb_muldiv_unit;
    import mips_pkg::*;

    logic clk;
    logic rst;
    int   errorCount;
    int   checkCount;

    muldiv_unit_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global watchdog so a stuck run still terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic waitDone(output int cycles, output int busyCycles);
        cycles     = 0;
        busyCycles = bus.busy ? 1 : 0;
        while (!bus.done && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
            if (bus.busy) busyCycles++;
        end
    endtask

    task automatic runOp(input string tag, input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expHi, input logic [31:0] expLo);
        int cycles;
        int busyCycles;
        applyStimulus(op, a, b);
        waitDone(cycles, busyCycles);
        checkOutput({tag, "_latency"}, 64'(cycles), 64'd33);
        checkOutput({tag, "_busy"}, 64'(busyCycles), 64'd33);
        checkOutput({tag, "_hi"}, {32'd0, bus.hi}, {32'd0, expHi});
        checkOutput({tag, "_lo"}, {32'd0, bus.lo}, {32'd0, expLo});
        @(posedge clk);
        #1;
        checkOutput({tag, "_donePulse"}, {63'd0, bus.done}, 64'd0);
    endtask

    initial begin
        int cycles;
        int busyCycles;
        int doneSeen;
        errorCount = 0;
        checkCount = 0;
        bus.start  = 1'b0;
        bus.op     = OP_MULT;
        bus.a      = '0;
        bus.b      = '0;
        rst        = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_busy", {63'd0, bus.busy}, 64'd0);
        checkOutput("reset_done", {63'd0, bus.done}, 64'd0);
        checkOutput("reset_hilo", {bus.hi, bus.lo}, 64'd0);

        runOp("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        runOp("mult_neg", OP_MULT, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        runOp("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        runOp("divu_zero", OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
        runOp("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        runOp("divu_plain", OP_DIVU, 32'd1000, 32'd7, 32'd6, 32'd142);

        applyStimulus(OP_MTLO, 32'h0000_1234, 32'd0);
        checkOutput("mtlo_lo", {32'd0, bus.lo}, 64'h1234);
        checkOutput("mtlo_hiKeep", {32'd0, bus.hi}, 64'd6);
        checkOutput("mtlo_busy", {63'd0, bus.busy}, 64'd0);

        // MTHI issued at E10 of a DIVU must be dropped.
        applyStimulus(OP_DIVU, 32'd50, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MTHI;
        bus.a     = 32'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkOutput("midop_hiHeld", {32'd0, bus.hi}, 64'd6);
        waitDone(cycles, busyCycles);
        checkOutput("midop_latency", 64'(cycles), 64'd23);
        checkOutput("midop_hi", {32'd0, bus.hi}, 64'd1);
        checkOutput("midop_lo", {32'd0, bus.lo}, 64'd7);

        applyStimulus(OP_MTHI, 32'd5, 32'd0);
        checkOutput("mthi_hi", {32'd0, bus.hi}, 64'd5);

        // Reset at E15 of a MULT aborts with no trailing done.
        applyStimulus(OP_MULT, 32'd3, 32'd4);
        repeat (15) @(posedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort_busy", {63'd0, bus.busy}, 64'd0);
        checkOutput("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) doneSeen++;
        end
        checkOutput("abort_noDone", 64'(doneSeen), 64'd0);

        runOp("mult_after", OP_MULT, 32'd12345, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_9F8E);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end
endmodule
